pixel_stream_reader: RTL and testbench

//  Reads a stored RGB image from the framebuffer BRAM in raster order and emits it as a

---
 rtl/pixel_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/pixel_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_pixel_stream_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel types, reader states and image defaults
package pixel_pkg;

  localparam int COLOR_W   = 12;
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pixel_stream_reader.sv
// rtl/pixel_stream_reader.sv - raster-order framebuffer reader emitting a tagged valid/ready pixel stream
module pixel_stream_reader #(
  parameter int IMG_W      = pixel_pkg::IMG_W_DEF,
  parameter int IMG_H      = pixel_pkg::IMG_H_DEF,
  parameter int COLOR_W    = pixel_pkg::COLOR_W,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = MEM_LAT + 2,
  parameter int ADDR_W     = $clog2(IMG_W * IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] out_rgb,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof
);

  import pixel_pkg::*;

  localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = $bits(pix_flags_t) + COLOR_W;
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              frame_done_q, frame_done_d;
  logic [MEM_LAT-1:0] pipe_vld_q;
  pix_flags_t        pipe_flg_q [MEM_LAT];

  pix_flags_t        cur_flags;
  pix_flags_t        head_flags;
  logic [COLOR_W-1:0] head_rgb;
  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              rd_en, push, pop, credit_ok;

  assign push      = pipe_vld_q[MEM_LAT-1];
  assign pop       = out_valid && out_ready;
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < CREDITS;
  // The credit check alone guarantees room; !fifo_full never changes the outcome.
  assign rd_en     = (state_q == ST_FETCH) && credit_ok && !fifo_full;

  assign cur_flags.sof = (x_q == '0) && (y_q == '0);
  assign cur_flags.eol = (x_q == X_LAST);
  assign cur_flags.eof = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      ST_FETCH: begin
        if (rd_en) begin
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Done when the last buffered pixel leaves and nothing is still in the BRAM pipe.
        if ((inflight_q == '0) && (fifo_count == CNT_W'(1)) && pop) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({rd_en, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      inflight_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Flags travel alongside each read so they meet their data at pipe exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_flg_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_en;
      pipe_flg_q[0] <= cur_flags;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_flg_q[i] <= pipe_flg_q[i-1];
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({pipe_flg_q[MEM_LAT-1], mem_data}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign {head_flags, head_rgb} = fifo_head;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign mem_rd_en  = rd_en;
  assign mem_addr   = addr_q;
  assign out_valid  = !fifo_empty;
  assign out_rgb    = out_valid ? head_rgb : '0;
  assign out_sof    = out_valid && head_flags.sof;
  assign out_eol    = out_valid && head_flags.eol;
  assign out_eof    = out_valid && head_flags.eof;

endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb/tb_pixel_stream_reader.sv - directed self-checking bench for pixel_stream_reader on a 4x2 image
module tb_pixel_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, frame_done, mem_rd_en, out_valid, out_sof, out_eol, out_eof;
  logic [2:0]  mem_addr;
  logic [11:0] mem_data, bram_s1, out_rgb;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int reads = 0;
  int fd_cnt = 0;
  int fd_cyc = -1;
  int stall_viol = 0;
  int credit_viol = 0;
  int outstanding = 0;
  logic        stall_prev = 1'b0;
  logic [11:0] stall_rgb = '0;
  logic [11:0] acc_rgb [$];
  logic [2:0]  acc_flg [$];
  int          acc_cyc [$];

  pixel_stream_reader #(
    .IMG_W   (4),
    .IMG_H   (2),
    .COLOR_W (12),
    .MEM_LAT (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rgb    (out_rgb),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM: mem[i] = 12'h100 + i
  always @(posedge clk) begin
    bram_s1  <= 12'h100 + {9'd0, mem_addr};
    mem_data <= bram_s1;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (stall_prev && (out_valid !== 1'b1 || out_rgb !== stall_rgb)) stall_viol++;
      if (mem_rd_en && outstanding >= 4) credit_viol++;
      if (mem_rd_en) reads++;
      if (out_valid && out_ready) begin
        acc_rgb.push_back(out_rgb);
        acc_flg.push_back({out_sof, out_eol, out_eof});
        acc_cyc.push_back(cyc);
      end
      outstanding = outstanding + (mem_rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      stall_rgb  = out_rgb;
    end
  end

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int f0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      if (fd_cnt > f0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if ({busy, frame_done, mem_rd_en, out_valid, out_sof, out_eol, out_eof, mem_addr, out_rgb} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b fd=%b rd=%b vld=%b flags=%b%b%b addr=%h rgb=%h, want all 0",
               busy, frame_done, mem_rd_en, out_valid, out_sof, out_eol, out_eof, mem_addr, out_rgb);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_start_ignored: got busy=%b rd=%b, want 0 0", busy, mem_rd_en);
    end
  endtask

  task automatic test_stream;
    int s, b, f0;
    bit ok;
    logic [11:0] exp_rgb;
    logic [2:0]  exp_flg;
    out_ready = 1'b1; b = acc_rgb.size(); f0 = fd_cnt;
    pulse_start(s);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL stream_busy: got %b want 1", busy); end
    wait_done(f0, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stream_done_timeout: got no frame_done, want pulse"); end
    n_cmp++;
    if (acc_rgb.size() - b != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", acc_rgb.size() - b); end
    for (int k = 0; k < 8; k++) begin
      exp_rgb = 12'h100 + 12'(k);
      exp_flg = {(k == 0), (k % 4 == 3), (k == 7)};
      n_cmp++;
      if (acc_rgb[b+k] !== exp_rgb || acc_flg[b+k] !== exp_flg || acc_cyc[b+k] != s + 4 + k) begin
        n_bad++;
        $display("FAIL stream_pix%0d: got rgb=%h flags=%b cyc=%0d, want rgb=%h flags=%b cyc=%0d",
                 k, acc_rgb[b+k], acc_flg[b+k], acc_cyc[b+k], exp_rgb, exp_flg, s + 4 + k);
      end
    end
    n_cmp++;
    if (fd_cyc != s + 12) begin n_bad++; $display("FAIL stream_done_cycle: got %0d want %0d", fd_cyc, s + 12); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int s, b, f0, sv0, cv0;
    bit ok;
    logic [11:0] exp_rgb;
    out_ready = 1'b1; b = acc_rgb.size(); f0 = fd_cnt; sv0 = stall_viol; cv0 = credit_viol;
    pulse_start(s);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      out_ready = !out_ready;
      if (fd_cnt > f0) ok = 1'b1;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_done_timeout: got no frame_done, want pulse"); end
    n_cmp++;
    if (acc_rgb.size() - b != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", acc_rgb.size() - b); end
    for (int k = 0; k < 8; k++) begin
      exp_rgb = 12'h100 + 12'(k);
      n_cmp++;
      if (acc_rgb[b+k] !== exp_rgb) begin
        n_bad++;
        $display("FAIL bp_pix%0d: got %h want %h", k, acc_rgb[b+k], exp_rgb);
      end
    end
    n_cmp++;
    if (stall_viol != sv0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable stalls want 0", stall_viol - sv0); end
    n_cmp++;
    if (credit_viol != cv0) begin n_bad++; $display("FAIL bp_credit: got %0d over-issues want 0", credit_viol - cv0); end
  endtask

  task automatic test_stall;
    int s, b, f0, r0, cv0;
    bit ok;
    logic [11:0] exp_rgb;
    out_ready = 1'b0; b = acc_rgb.size(); f0 = fd_cnt; r0 = reads; cv0 = credit_viol;
    pulse_start(s);
    repeat (19) begin @(posedge clk); #1; end
    n_cmp++;
    if (reads - r0 != 4) begin n_bad++; $display("FAIL stall_reads: got %0d want 4", reads - r0); end
    n_cmp++;
    if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL stall_rd_en: got %b want 0", mem_rd_en); end
    out_ready = 1'b1;
    wait_done(f0, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stall_done_timeout: got no frame_done, want pulse"); end
    n_cmp++;
    if (acc_rgb.size() - b != 8) begin n_bad++; $display("FAIL stall_count: got %0d want 8", acc_rgb.size() - b); end
    for (int k = 0; k < 8; k++) begin
      exp_rgb = 12'h100 + 12'(k);
      n_cmp++;
      if (acc_rgb[b+k] !== exp_rgb) begin
        n_bad++;
        $display("FAIL stall_pix%0d: got %h want %h", k, acc_rgb[b+k], exp_rgb);
      end
    end
    n_cmp++;
    if (credit_viol != cv0) begin n_bad++; $display("FAIL stall_credit: got %0d over-issues want 0", credit_viol - cv0); end
  endtask

  task automatic test_restart_ignored;
    int s, b, f0;
    bit ok;
    logic [11:0] exp_rgb;
    out_ready = 1'b1; b = acc_rgb.size(); f0 = fd_cnt;
    pulse_start(s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(f0, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL restart_done_timeout: got no frame_done, want pulse"); end
    for (int k = 0; k < 8; k++) begin
      exp_rgb = 12'h100 + 12'(k);
      n_cmp++;
      if (acc_rgb[b+k] !== exp_rgb || acc_cyc[b+k] != s + 4 + k) begin
        n_bad++;
        $display("FAIL restart_pix%0d: got rgb=%h cyc=%0d want rgb=%h cyc=%0d",
                 k, acc_rgb[b+k], acc_cyc[b+k], exp_rgb, s + 4 + k);
      end
    end
    n_cmp++;
    if (fd_cyc != s + 12) begin n_bad++; $display("FAIL restart_done_cycle: got %0d want %0d", fd_cyc, s + 12); end
    repeat (15) begin @(negedge clk); #1; end
    n_cmp++;
    if (fd_cnt - f0 != 1 || busy !== 1'b0 || acc_rgb.size() - b != 8) begin
      n_bad++;
      $display("FAIL restart_single_frame: got frames=%0d busy=%b pixels=%0d want 1 0 8",
               fd_cnt - f0, busy, acc_rgb.size() - b);
    end
  endtask

  task automatic test_abort;
    int s, s2, b, f0;
    bit ok;
    logic [11:0] exp_rgb;
    logic [2:0]  exp_flg;
    out_ready = 1'b1; b = acc_rgb.size(); f0 = fd_cnt;
    pulse_start(s);
    for (int i = 0; i < 20 && cyc != s + 7; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (acc_rgb.size() - b != 3) begin n_bad++; $display("FAIL abort_pre_count: got %0d want 3", acc_rgb.size() - b); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, frame_done, mem_rd_en, out_valid, out_sof, out_eol, out_eof, mem_addr, out_rgb} !== 22'd0) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b fd=%b rd=%b vld=%b flags=%b%b%b addr=%h rgb=%h, want all 0",
               busy, frame_done, mem_rd_en, out_valid, out_sof, out_eol, out_eof, mem_addr, out_rgb);
    end
    repeat (20) begin @(negedge clk); #1; end
    n_cmp++;
    if (fd_cnt != f0 || busy !== 1'b0 || acc_rgb.size() - b != 3) begin
      n_bad++;
      $display("FAIL abort_quiet: got frames=%0d busy=%b pixels=%0d want 0 0 3", fd_cnt - f0, busy, acc_rgb.size() - b);
    end
    b = acc_rgb.size();
    pulse_start(s2);
    wait_done(f0, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL abort_restart_timeout: got no frame_done, want pulse"); end
    for (int k = 0; k < 8; k++) begin
      exp_rgb = 12'h100 + 12'(k);
      exp_flg = {(k == 0), (k % 4 == 3), (k == 7)};
      n_cmp++;
      if (acc_rgb[b+k] !== exp_rgb || acc_flg[b+k] !== exp_flg) begin
        n_bad++;
        $display("FAIL abort_pix%0d: got rgb=%h flags=%b want rgb=%h flags=%b", k, acc_rgb[b+k], acc_flg[b+k], exp_rgb, exp_flg);
      end
    end
    n_cmp++;
    if (fd_cyc != s2 + 12) begin n_bad++; $display("FAIL abort_done_cycle: got %0d want %0d", fd_cyc, s2 + 12); end
  endtask

  task automatic test_back_to_back;
    int s, s2, b, f0;
    bit ok;
    logic [11:0] exp_rgb;
    logic [2:0]  exp_flg;
    out_ready = 1'b1; b = acc_rgb.size(); f0 = fd_cnt;
    pulse_start(s);
    for (int i = 0; i < 40 && cyc != s + 12; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (frame_done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b want 1", frame_done); end
    start = 1'b1;
    s2 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(f0 + 1, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_done_timeout: got frames=%0d want 2", fd_cnt - f0); end
    n_cmp++;
    if (acc_rgb.size() - b != 16) begin n_bad++; $display("FAIL b2b_count: got %0d want 16", acc_rgb.size() - b); end
    for (int k = 0; k < 8; k++) begin
      exp_rgb = 12'h100 + 12'(k);
      exp_flg = {(k == 0), (k % 4 == 3), (k == 7)};
      n_cmp++;
      if (acc_rgb[b+8+k] !== exp_rgb || acc_flg[b+8+k] !== exp_flg || acc_cyc[b+8+k] != s2 + 4 + k) begin
        n_bad++;
        $display("FAIL b2b_pix%0d: got rgb=%h flags=%b cyc=%0d want rgb=%h flags=%b cyc=%0d",
                 k, acc_rgb[b+8+k], acc_flg[b+8+k], acc_cyc[b+8+k], exp_rgb, exp_flg, s2 + 4 + k);
      end
    end
    n_cmp++;
    if (fd_cyc != s2 + 12) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", fd_cyc, s2 + 12); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, want earlier finish");
    $fatal(1);
  end

endmodule
